// File: rtl/timer_input_ctrl.sv
// Keypad entry and countdown sequencer for the microwave TimerInput datapath.
// Collects MM:SS BCD digits, loads the countdown once on start, then tracks run, pause, abort and done.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | no entry, keypad display, waiting for the first digit
//  ENTRY   | collecting up to four digits, keypad display
//  LOAD    | one-cycle load of the clamped entry into the countdown
//  RUN     | countdown decrementing, countdown display
//  PAUSE   | door open while cooking, countdown held and displayed

module timer_input_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_code,
    input  logic        i_clear,
    input  logic        i_start,
    input  logic        i_door_closed,
    input  logic        i_timer_zero,
    output logic [15:0] o_entry_bcd,
    output logic [15:0] o_load_value,
    output logic        o_load,
    output logic        o_sel,
    output logic        o_run_en,
    output logic        o_done,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_entry;
    logic [15:0] w_entry_nxt;
    logic [2:0]  r_count;
    logic [2:0]  w_count_nxt;
    logic [15:0] r_load_value;
    logic        r_load;
    logic        r_sel;
    logic        r_run_en;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_is_digit;
    logic [15:0] w_clamped;

    assign w_is_digit = i_key_valid && (i_key_code <= 4'd9);

    // Seconds above 59 are shown as 59; minutes pass through untouched.
    assign w_clamped = (r_entry[7:4] > 4'd5) ? {r_entry[15:8], 8'h59} : r_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_entry_nxt = r_entry;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_entry_nxt = '0;
                w_count_nxt = '0;
                if (!i_clear && !i_start && w_is_digit) begin
                    w_entry_nxt = {12'h000, i_key_code};
                    w_count_nxt = 3'd1;
                    w_state_nxt = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (i_clear) begin
                    w_entry_nxt = '0;
                    w_count_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (i_start) begin
                    if (i_door_closed && (r_entry != 16'h0000)) begin
                        w_state_nxt = S_LOAD;
                    end
                end else if (w_is_digit && (r_count < 3'd4)) begin
                    w_entry_nxt = {r_entry[11:0], i_key_code};
                    w_count_nxt = r_count + 3'd1;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // Completion outranks both abort and door-open in the same cycle.
                if (i_timer_zero) begin
                    w_entry_nxt = '0;
                    w_count_nxt = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (i_clear) begin
                    w_entry_nxt = '0;
                    w_count_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (!i_door_closed) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (i_clear) begin
                    w_entry_nxt = '0;
                    w_count_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (i_start && i_door_closed) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_entry_nxt = '0;
                w_count_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with o_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry      <= '0;
            r_count      <= '0;
            r_load_value <= '0;
            r_load       <= 1'b0;
            r_sel        <= 1'b0;
            r_run_en     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_entry  <= w_entry_nxt;
            r_count  <= w_count_nxt;
            r_load   <= (w_state_nxt == S_LOAD);
            r_sel    <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
            r_run_en <= (w_state_nxt == S_RUN);
            r_done   <= w_done_nxt;
            if (w_state_nxt == S_LOAD) begin
                r_load_value <= w_clamped;
            end
        end
    end

    assign o_entry_bcd  = r_entry;
    assign o_load_value = r_load_value;
    assign o_load       = r_load;
    assign o_sel        = r_sel;
    assign o_run_en     = r_run_en;
    assign o_done       = r_done;
    assign o_state      = r_state;

endmodule

// File: tb/tb_timer_input_ctrl.sv
// Bench for timer_input_ctrl: directed vector table, reset corner cases and
// random stimulus against a digit-list reference model.

module tb_timer_input_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_key_valid;
    logic [3:0]  i_key_code;
    logic        i_clear;
    logic        i_start;
    logic        i_door_closed;
    logic        i_timer_zero;
    logic [15:0] o_entry_bcd;
    logic [15:0] o_load_value;
    logic        o_load;
    logic        o_sel;
    logic        o_run_en;
    logic        o_done;
    logic [2:0]  o_state;

    int n_checks = 0;
    int n_errors = 0;

    timer_input_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_key_valid  (i_key_valid),
        .i_key_code   (i_key_code),
        .i_clear      (i_clear),
        .i_start      (i_start),
        .i_door_closed(i_door_closed),
        .i_timer_zero (i_timer_zero),
        .o_entry_bcd  (o_entry_bcd),
        .o_load_value (o_load_value),
        .o_load       (o_load),
        .o_sel        (o_sel),
        .o_run_en     (o_run_en),
        .o_done       (o_done),
        .o_state      (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        clr;
        logic        st;
        logic        kv;
        logic [3:0]  kc;
        logic        door;
        logic        tz;
        logic [2:0]  e_state;
        logic [15:0] e_entry;
        logic        e_load;
        logic [15:0] e_lv;
        logic        e_sel;
        logic        e_run;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the entry is a list of typed digits, phases use the published encodings.
    int m_phase;
    int m_digits[$];
    int m_lv;
    bit m_load;
    bit m_done;

    function automatic int entry_val();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return v;
    endfunction

    function automatic int clamp_secs(input int v);
        if (((v / 16) % 16) > 5) return (v / 256) * 256 + 'h59;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_digits.delete();
        m_lv   = 0;
        m_load = 0;
        m_done = 0;
    endtask

    task automatic model_step(input bit c, input bit s, input bit kv, input int kc,
                              input bit d, input bit t);
        m_load = 0;
        m_done = 0;
        case (m_phase)
            0: if (!c && !s && kv && kc <= 9) begin
                m_digits.delete();
                m_digits.push_back(kc);
                m_phase = 1;
            end
            1: if (c) begin
                m_digits.delete();
                m_phase = 0;
            end else if (s) begin
                if (d && entry_val() != 0) begin
                    m_phase = 2;
                    m_load  = 1;
                    m_lv    = clamp_secs(entry_val());
                end
            end else if (kv && kc <= 9 && m_digits.size() < 4) begin
                m_digits.push_back(kc);
            end
            2: m_phase = 3;
            3: if (t) begin
                m_digits.delete();
                m_phase = 0;
                m_done  = 1;
            end else if (c) begin
                m_digits.delete();
                m_phase = 0;
            end else if (!d) begin
                m_phase = 4;
            end
            4: if (c) begin
                m_digits.delete();
                m_phase = 0;
            end else if (s && d) begin
                m_phase = 3;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] e_state, input logic [15:0] e_entry,
                           input logic e_load, input logic [15:0] e_lv, input logic e_sel,
                           input logic e_run, input logic e_done);
        chk({tag, ".state"},      16'(o_state),  16'(e_state));
        chk({tag, ".entry_bcd"},  o_entry_bcd,   e_entry);
        chk({tag, ".load"},       16'(o_load),   16'(e_load));
        chk({tag, ".load_value"}, o_load_value,  e_lv);
        chk({tag, ".sel"},        16'(o_sel),    16'(e_sel));
        chk({tag, ".run_en"},     16'(o_run_en), 16'(e_run));
        chk({tag, ".done"},       16'(o_done),   16'(e_done));
    endtask

    task automatic model_check(input string tag);
        chk_all(tag, 3'(m_phase), 16'(entry_val()), m_load, 16'(m_lv),
                (m_phase >= 2 && m_phase <= 4), (m_phase == 3), m_done);
    endtask

    task automatic step_cyc(input bit c, input bit s, input bit kv, input logic [3:0] kc,
                            input bit d, input bit t);
        i_clear       = c;
        i_start       = s;
        i_key_valid   = kv;
        i_key_code    = kc;
        i_door_closed = d;
        i_timer_zero  = t;
        @(posedge clk);
        #1;
        model_step(c, s, kv, int'(kc), d, t);
    endtask

    task automatic add(input logic c, input logic s, input logic kv, input logic [3:0] kc,
                       input logic d, input logic t, input logic [2:0] es, input logic [15:0] ee,
                       input logic el, input logic [15:0] elv, input logic esel,
                       input logic er, input logic ed);
        vecs.push_back({c, s, kv, kc, d, t, es, ee, el, elv, esel, er, ed});
    endtask

    initial begin
        bit door;

        // clr st kv kc door tz | state entry load lv sel run done
        add(0,0,1, 1,1,0, 1,16'h0001,0,16'h0000,0,0,0);
        add(0,0,1, 2,1,0, 1,16'h0012,0,16'h0000,0,0,0);
        add(0,0,1, 3,1,0, 1,16'h0123,0,16'h0000,0,0,0);
        add(0,0,1, 0,1,0, 1,16'h1230,0,16'h0000,0,0,0);
        add(0,0,1, 7,1,0, 1,16'h1230,0,16'h0000,0,0,0);
        add(1,0,1, 5,1,0, 0,16'h0000,0,16'h0000,0,0,0);
        add(0,0,1,12,1,0, 0,16'h0000,0,16'h0000,0,0,0);
        add(0,1,0, 0,1,0, 0,16'h0000,0,16'h0000,0,0,0);
        add(0,0,1, 0,1,0, 1,16'h0000,0,16'h0000,0,0,0);
        add(0,1,0, 0,1,0, 1,16'h0000,0,16'h0000,0,0,0);
        add(0,0,1, 0,1,0, 1,16'h0000,0,16'h0000,0,0,0);
        add(0,0,1, 7,1,0, 1,16'h0007,0,16'h0000,0,0,0);
        add(0,0,1, 5,1,0, 1,16'h0075,0,16'h0000,0,0,0);
        add(0,1,0, 0,0,0, 1,16'h0075,0,16'h0000,0,0,0);
        add(0,1,0, 0,1,0, 2,16'h0075,1,16'h0059,1,0,0);
        add(0,0,0, 0,1,0, 3,16'h0075,0,16'h0059,1,1,0);
        add(0,0,0, 0,0,0, 4,16'h0075,0,16'h0059,1,0,0);
        add(0,1,0, 0,0,0, 4,16'h0075,0,16'h0059,1,0,0);
        add(0,0,0, 0,1,0, 4,16'h0075,0,16'h0059,1,0,0);
        add(0,1,0, 0,1,0, 3,16'h0075,0,16'h0059,1,1,0);
        add(0,0,0, 0,1,1, 0,16'h0000,0,16'h0059,0,0,1);
        add(0,0,0, 0,1,0, 0,16'h0000,0,16'h0059,0,0,0);
        add(0,0,1, 9,1,0, 1,16'h0009,0,16'h0059,0,0,0);
        add(0,1,0, 0,1,0, 2,16'h0009,1,16'h0009,1,0,0);
        add(0,0,0, 0,1,0, 3,16'h0009,0,16'h0009,1,1,0);
        add(1,0,0, 0,1,0, 0,16'h0000,0,16'h0009,0,0,0);
        add(0,0,1, 4,1,0, 1,16'h0004,0,16'h0009,0,0,0);
        add(0,1,0, 0,1,0, 2,16'h0004,1,16'h0004,1,0,0);
        add(0,0,0, 0,1,0, 3,16'h0004,0,16'h0004,1,1,0);
        add(0,0,0, 0,0,1, 0,16'h0000,0,16'h0004,0,0,1);
        add(0,0,0, 0,1,0, 0,16'h0000,0,16'h0004,0,0,0);
        add(0,0,1, 9,1,0, 1,16'h0009,0,16'h0004,0,0,0);
        add(0,0,1, 9,1,0, 1,16'h0099,0,16'h0004,0,0,0);
        add(0,0,1, 9,1,0, 1,16'h0999,0,16'h0004,0,0,0);
        add(0,0,1, 9,1,0, 1,16'h9999,0,16'h0004,0,0,0);
        add(0,1,0, 0,1,0, 2,16'h9999,1,16'h9959,1,0,0);
        add(1,0,0, 0,1,0, 3,16'h9999,0,16'h9959,1,1,0);
        add(1,0,0, 0,1,0, 0,16'h0000,0,16'h9959,0,0,0);

        rst_n         = 1'b0;
        i_clear       = 1'b0;
        i_start       = 1'b0;
        i_key_valid   = 1'b0;
        i_key_code    = 4'd0;
        i_door_closed = 1'b1;
        i_timer_zero  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step_cyc(vecs[i].clr, vecs[i].st, vecs[i].kv, vecs[i].kc, vecs[i].door, vecs[i].tz);
            chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_entry, vecs[i].e_load,
                    vecs[i].e_lv, vecs[i].e_sel, vecs[i].e_run, vecs[i].e_done);
        end

        // Asynchronous reset while cooking, then first edge after release.
        step_cyc(0,0,1,4'd2,1,0);
        step_cyc(0,1,0,4'd0,1,0);
        step_cyc(0,0,0,4'd0,1,0);
        chk_all("pre_rst_run", 3'd3, 16'h0002, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        model_reset();
        i_key_valid = 1'b1;
        i_key_code  = 4'd6;
        @(posedge clk);
        #1;
        chk_all("rst_held", 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step_cyc(0,0,1,4'd6,1,0);
        chk_all("post_rst_key", 3'd1, 16'h0006, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        door = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            bit c, s, kv, t;
            if ($urandom_range(0, 7) == 0) door = ~door;
            c  = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 5) == 0);
            kv = ($urandom_range(0, 1) == 1);
            t  = ($urandom_range(0, 14) == 0);
            step_cyc(c, s, kv, 4'($urandom_range(0, 15)), door, t);
            model_check($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_input_ctrl.md
# timer_input_ctrl

Sequencer for the TimerInput datapath of the microwave controller. Collects MM:SS keypad digits into a 4-digit BCD entry buffer and drives the 2:1 mux select that chooses between the keypad entry and the countdown value. Issues a one-cycle load into the countdown timer on a valid start, and manages run, pause (door open), abort and done.

## Interface

- Parameters: none (fixed 4 BCD digits, MM:SS).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid this cycle.
- `key_code`  in  4  keypad code; 0–9 are digits, 10–15 are ignored.
- `clear`  in  1  one-cycle strobe; clears entry or aborts cooking.
- `start`  in  1  one-cycle strobe; requests start or resume.
- `door_closed`  in  1  level; 1 means the door is closed.
- `timer_zero`  in  1  level from the countdown; 1 means the count is 00:00.
- `entry_bcd`  out  16  entry buffer {M1,M0,S1,S0}; feeds mux input a.
- `load_value`  out  16  normalized entry presented to the countdown load port.
- `load`  out  1  one-cycle load strobe to the countdown.
- `sel`  out  1  mux select; 0 = keypad entry shown, 1 = countdown shown.
- `run_en`  out  1  countdown decrement enable.
- `done`  out  1  one-cycle pulse when cooking completes.
- `state`  out  3  current FSM state, for debug and display.

## Operation

- States and encodings: IDLE=0, ENTRY=1, LOAD=2, RUN=3, PAUSE=4. All outputs are registered.
- Input priority within a cycle: `clear` > `start` > `key_valid`. A lower-priority event in the same cycle is dropped, not deferred.
- IDLE: `entry_bcd`=0 and digit count=0.
  - A digit key (`key_code` ≤ 9) sets `entry_bcd`={12'h000,code}, count=1, and moves to ENTRY.
  - `start` in IDLE is ignored.
- ENTRY:
  - A digit key shifts left: `entry_bcd`={entry_bcd[11:0],code}, count+1.
  - When count=4, further digits are ignored; the count saturates at 4.
  - `clear` zeroes the entry and the count and returns to IDLE.
  - `start` with `door_closed`=1 and `entry_bcd`≠0 goes to LOAD. Otherwise `start` is ignored.
- LOAD: lasts exactly one cycle.
  - `load`=1.
  - `load_value`=`entry_bcd` with seconds clamped: if S1>5, then S1=5 and S0=9. Minutes are not altered.
  - Next state is RUN.
- RUN: `sel`=1 and `run_en`=1. Keys are ignored.
  - `timer_zero`=1 returns to IDLE with `done`=1 for one cycle and the entry cleared.
  - `door_closed`=0 goes to PAUSE.
  - `clear` aborts to IDLE with the entry cleared and no `done`.
  - If `timer_zero` and door-open occur together, `timer_zero` wins.
- PAUSE: `sel`=1 and `run_en`=0. Keys are ignored.
  - `start` with `door_closed`=1 returns to RUN.
  - `clear` returns to IDLE with the entry cleared.
  - `start` with the door open is ignored.
- `sel`=0 in IDLE and ENTRY; `sel`=1 in LOAD, RUN and PAUSE.
- `load_value` holds its last loaded value outside LOAD.

## Timing

- Reset values: `state`=IDLE, `entry_bcd`=0, `load_value`=0, `load`=0, `sel`=0, `run_en`=0, `done`=0. Digit count=0.
- Reset asserted mid-operation (any state) forces the reset values immediately, asynchronously. The first state change happens on the first rising edge after `rst_n` rises.
- A key sampled at edge N appears in `entry_bcd` after edge N.
- `start` sampled at edge N (in ENTRY) gives `state`=LOAD and `load`=1 after edge N. After edge N+1: `state`=RUN, `run_en`=1, `load`=0.
- `sel` rises together with `load` (after edge N), so the display switches in the same cycle the countdown loads.
- `timer_zero` sampled at edge M in RUN: after edge M, `state`=IDLE, `run_en`=0, `sel`=0 and `done`=1. After edge M+1, `done`=0.
- Door opening sampled at edge P in RUN drops `run_en` after edge P. There is no extra decrement.

## Test plan

- Reset, then keys 1,2,3,0 → `entry_bcd`=16'h1230, `state`=ENTRY, `sel`=0. A fifth key 7 leaves it at 16'h1230.
- Entry 0,0,7,5 plus `start` with the door closed → `load` pulses for 1 cycle with `load_value`=16'h0059 (clamped). Then `run_en`=1 and `sel`=1.
- `start` with `entry_bcd`=0, or with `door_closed`=0 → `state` stays put and `load` never asserts.
- RUN, then `door_closed`=0 → PAUSE with `run_en`=0. `start` while the door is open is ignored. Closing the door and pulsing `start` → RUN with `run_en`=1.
- RUN plus `timer_zero`=1 → one-cycle `done`=1, then IDLE with `entry_bcd`=0 and `sel`=0. `clear` in RUN → IDLE with no `done`.
- Same-cycle `clear` and `key_valid` (code 5) in ENTRY → `entry_bcd`=0 and IDLE. Key code 12 in IDLE → no change. `rst_n` low during RUN → all outputs at reset values immediately.
